// File: rtl/win_stream_pkg.sv
// Shared definitions for the streaming window multiplier: mode and FSM encodings
// and the elaboration-time half-sine coefficient generator.
package win_pkg;

  typedef enum logic [1:0] {
    WIN_RECT   = 2'd0,
    WIN_SINE   = 2'd1,
    WIN_HANN   = 2'd2,
    WIN_BYPASS = 2'd3
  } win_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } win_state_e;

  // round((2^cw-1) * sin(pi*(k+0.5)/2^log2n)); the angle stays below pi/2, so a
  // short Taylor series is exact to well below one LSB.
  function automatic int unsigned win_half_sine(input int k, input int log2n, input int cw);
    real pi;
    real ang;
    real term;
    real sum;
    real amp;
    pi   = 3.14159265358979323846;
    ang  = pi * (real'(k) + 0.5) / real'(1 << log2n);
    term = ang;
    sum  = ang;
    for (int i = 1; i < 12; i++) begin
      term = -term * ang * ang / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    amp = real'((1 << cw) - 1);
    return $rtoi(amp * sum + 0.5);
  endfunction

endpackage

// File: rtl/win_stream_coef_rom.sv
// Synchronous half-sine coefficient ROM: data_o = s(addr_i) one cycle after the address.
module win_coef_rom
  import win_pkg::*;
#(
  parameter int LOG2N = 7,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic [LOG2N-2:0] addr_i,
  output logic [CW-1:0]    data_o
);

  localparam int HALF = 1 << (LOG2N - 1);

  logic [CW-1:0] table_w [HALF];
  logic [CW-1:0] data_q;

  for (genvar k = 0; k < HALF; k++) begin : g_tab
    localparam int unsigned S = win_half_sine(k, LOG2N, CW);
    assign table_w[k] = CW'(S);
  end

  always_ff @(posedge clk) begin
    data_q <= table_w[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/win_stream.sv
// Streaming window multiplier: rect / half-sine / Hann / bypass weighting of NCH
// signed channels over 2^LOG2N-sample frames, fixed 4-cycle latency.
module win_stream
  import win_pkg::*;
#(
  parameter int DW    = 12,
  parameter int CW    = 16,
  parameter int LOG2N = 7,
  parameter int NCH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                in_valid,
  input  logic [NCH*DW-1:0]   in_data,
  output logic                out_valid,
  output logic [NCH*DW-1:0]   out_data,
  output logic                out_first,
  output logic                out_last,
  output logic                busy,
  output logic                restart_err
);

  localparam int N  = 1 << LOG2N;
  localparam int PW = DW + CW + 1;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
  localparam logic [PW-1:0]    P_RND    = PW'(1) << (CW - 1);
  localparam logic [2*CW-1:0]  H_RND    = (2 * CW)'(1) << (CW - 1);

  // Handshake: in_valid is a one-way strobe with no ready. A sample is taken
  // whenever in_valid is high and either the FSM is in RUN or start is high in
  // the same cycle; out_valid is likewise a strobe the consumer must accept.

  // ---------------- frame FSM ----------------
  win_state_e       state_q;
  logic [LOG2N-1:0] cnt_q;
  win_mode_e        mode_q;
  logic             busy_q;
  logic             restart_err_q;

  logic [LOG2N-1:0] cnt_cur;
  win_mode_e        mode_cur;
  logic             accept;
  logic [LOG2N-2:0] rom_addr;

  assign cnt_cur  = start ? '0 : cnt_q;
  assign mode_cur = start ? win_mode_e'(mode) : mode_q;
  assign accept   = in_valid && (start || (state_q == ST_RUN));
  // Second half of the frame mirrors onto the table: N-1-cnt == ~cnt in LOG2N bits.
  assign rom_addr = cnt_cur[LOG2N-1] ? ~cnt_cur[LOG2N-2:0] : cnt_cur[LOG2N-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mode_q        <= WIN_RECT;
      busy_q        <= 1'b0;
      restart_err_q <= 1'b0;
    end else if (start) begin
      state_q <= ST_RUN;
      busy_q  <= 1'b1;
      mode_q  <= win_mode_e'(mode);
      cnt_q   <= in_valid ? LOG2N'(1) : '0;
      if (state_q == ST_RUN) begin
        restart_err_q <= 1'b1;
      end
    end else if ((state_q == ST_RUN) && in_valid) begin
      if (cnt_q == CNT_LAST) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + LOG2N'(1);
      end
    end
  end

  assign busy        = busy_q;
  assign restart_err = restart_err_q;

  // ---------------- S1: input register + ROM read ----------------
  logic [CW-1:0]     rom_data;
  logic              v1_q, first1_q, last1_q;
  win_mode_e         mode1_q;
  logic [NCH*DW-1:0] x1_q;

  win_coef_rom #(
    .LOG2N (LOG2N),
    .CW    (CW)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      mode1_q  <= WIN_RECT;
      x1_q     <= '0;
    end else begin
      v1_q     <= accept;
      first1_q <= accept && (cnt_cur == '0);
      last1_q  <= accept && (cnt_cur == CNT_LAST);
      mode1_q  <= mode_cur;
      x1_q     <= in_data;
    end
  end

  // ---------------- S2: Hann square and coefficient select ----------------
  logic [2*CW-1:0] sq_w;
  logic [2*CW-1:0] hann_sum;
  logic [CW-1:0]   hann_c;
  logic [CW-1:0]   unused_hann_frac;
  logic [CW-1:0]   coef_d;

  assign sq_w             = {{CW{1'b0}}, rom_data} * {{CW{1'b0}}, rom_data};
  assign hann_sum         = sq_w + H_RND;
  assign hann_c           = hann_sum[2*CW-1:CW];
  assign unused_hann_frac = hann_sum[CW-1:0];

  always_comb begin
    coef_d = '1;
    case (mode1_q)
      WIN_SINE: coef_d = rom_data;
      WIN_HANN: coef_d = hann_c;
      default:  coef_d = '1;
    endcase
  end

  logic              v2_q, first2_q, last2_q, byp2_q;
  logic [CW-1:0]     coef2_q;
  logic [NCH*DW-1:0] x2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      byp2_q   <= 1'b0;
      coef2_q  <= '0;
      x2_q     <= '0;
    end else begin
      v2_q     <= v1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      byp2_q   <= (mode1_q == WIN_BYPASS);
      coef2_q  <= coef_d;
      x2_q     <= x1_q;
    end
  end

  // ---------------- S3 multiply / S4 round: shared control ----------------
  logic              v3_q, first3_q, last3_q, byp3_q;
  logic [NCH*DW-1:0] x3_q;
  logic              v4_q, first4_q, last4_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q     <= 1'b0;
      first3_q <= 1'b0;
      last3_q  <= 1'b0;
      byp3_q   <= 1'b0;
      x3_q     <= '0;
      v4_q     <= 1'b0;
      first4_q <= 1'b0;
      last4_q  <= 1'b0;
    end else begin
      v3_q     <= v2_q;
      first3_q <= first2_q;
      last3_q  <= last2_q;
      byp3_q   <= byp2_q;
      x3_q     <= x2_q;
      v4_q     <= v3_q;
      first4_q <= first3_q;
      last4_q  <= last3_q;
    end
  end

  assign out_valid = v4_q;
  assign out_first = first4_q;
  assign out_last  = last4_q;

  // ---------------- per-channel datapath ----------------
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic signed [DW-1:0] x2_s;
    logic signed [DW-1:0] x3_s;
    logic signed [PW-1:0] p_q;
    logic signed [PW-1:0] p_rnd;
    logic signed [DW-1:0] y_q;
    logic [CW-1:0]        unused_frac;
    logic                 unused_sign;

    assign x2_s  = x2_q[ch*DW +: DW];
    assign x3_s  = x3_q[ch*DW +: DW];
    assign p_rnd = p_q + $signed(P_RND);
    // |y| <= |x|, so the top product bit is only a sign copy and can be dropped.
    assign unused_frac = p_rnd[CW-1:0];
    assign unused_sign = p_rnd[PW-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        p_q <= '0;
        y_q <= '0;
      end else begin
        p_q <= PW'(x2_s) * PW'($signed({1'b0, coef2_q}));
        y_q <= byp3_q ? x3_s : p_rnd[CW +: DW];
      end
    end

    assign out_data[ch*DW +: DW] = y_q;
  end

endmodule

// File: tb/tb_win_stream.sv
// Directed bench for win_stream: scoreboard of expected samples with arrival
// cycles, plus spot checks of window values, markers, restart and reset.
module tb_win_stream;
  import win_pkg::*;

  localparam int DW    = 12;
  localparam int CW    = 16;
  localparam int LOG2N = 7;
  localparam int NCH   = 2;
  localparam int N     = 1 << LOG2N;
  localparam int DWT   = NCH * DW;
  localparam int W     = DWT + 2;
  localparam logic [DW-1:0] P2047 = 12'h7FF;
  localparam logic [DW-1:0] M2048 = 12'h800;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic           in_valid = 1'b0;
  logic [DWT-1:0] in_data = '0;
  logic           out_valid, out_first, out_last, busy, restart_err;
  logic [DWT-1:0] out_data;

  win_stream #(.DW(DW), .CW(CW), .LOG2N(LOG2N), .NCH(NCH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_first   (out_first),
    .out_last    (out_last),
    .busy        (busy),
    .restart_err (restart_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- output monitor (capture only) ----------------
  logic [W-1:0] obs_pk [4096];
  int           obs_cyc[4096];
  int           obs_n = 0;
  always @(negedge clk) begin
    if (out_valid === 1'b1 && obs_n < 4096) begin
      obs_pk[obs_n]  = {out_first, out_last, out_data};
      obs_cyc[obs_n] = cyc;
      obs_n          = obs_n + 1;
    end
  end

  // ---------------- scoreboard and model ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] log_q[$];
  int           rd = 0;
  int           n_assert = 0;
  int           n_fail = 0;
  bit           m_run = 0;
  int           m_cnt = 0;
  int           m_mode = 0;

  function automatic longint s_ref(input int k);
    real a;
    a = real'((1 << CW) - 1) * $sin(3.14159265358979323846 * (real'(k) + 0.5) / real'(N));
    return longint'($rtoi(a + 0.5));
  endfunction

  function automatic logic [DW-1:0] model_y(input logic [DW-1:0] x, input int md, input int cnt);
    logic signed [DW-1:0] xs;
    longint s, c, p, y;
    int k;
    xs = x;
    k  = (cnt < N / 2) ? cnt : N - 1 - cnt;
    s  = s_ref(k);
    if (md == 3) return x;
    if (md == 1) c = s;
    else if (md == 2) c = (s * s + (longint'(1) << (CW - 1))) >> CW;
    else c = (longint'(1) << CW) - 1;
    p = longint'(xs) * c;
    y = (p + (longint'(1) << (CW - 1))) >>> CW;
    return y[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] ch(input logic [W-1:0] pk, input int c);
    return pk[c*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_pk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [DWT-1:0] d, input int md, input int cnt);
    logic [W-1:0] e;
    e[W-1] = (cnt == 0);
    e[W-2] = (cnt == N - 1);
    for (int c = 0; c < NCH; c++) e[c*DW +: DW] = model_y(d[c*DW +: DW], md, cnt);
    exp_q.push_back(e);
    lat_q.push_back(cyc + 4);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit st, input bit v, input logic [1:0] m, input logic [DWT-1:0] d);
    start = st; in_valid = v; mode = m; in_data = d;
    if (st) begin
      m_run = 1; m_mode = m; m_cnt = 0;
    end
    if (v && m_run) begin
      push_exp(d, m_mode, m_cnt);
      if (m_cnt == N - 1) begin m_run = 0; m_cnt = 0; end
      else m_cnt++;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic drain();
    logic [W-1:0] e;
    int l;
    while (rd < obs_n) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out: output %h at cycle %0d, expected none", obs_pk[rd], obs_cyc[rd]);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk_pk("out_sample", obs_pk[rd], e);
        chk("out_cycle", obs_cyc[rd], l);
      end
      log_q.push_back(obs_pk[rd]);
      rd++;
    end
  endtask

  task automatic frame(input logic [1:0] m, input logic [DWT-1:0] d);
    log_q.delete();
    for (int i = 0; i < N; i++) drive(i == 0, 1'b1, m, d);
    idle(6);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); lat_q.delete(); log_q.delete();
    rd = obs_n; m_run = 0; m_cnt = 0; m_mode = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_at, n_first, n_last;
    bit sym;
    longint v63;
    logic [DWT-1:0] rd_data;

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_restart_err", restart_err, 0);

    // Sine, full-scale positive
    frame(WIN_SINE, {P2047, P2047});
    chk("sine_p_count", log_q.size(), N);
    chk("sine_p_k0", ch(log_q[0], 0), 25);
    chk("sine_p_k63", ch(log_q[63], 0), 2047);
    chk("sine_p_k64", ch(log_q[64], 1), 2047);
    chk("sine_p_k127", ch(log_q[127], 1), 25);
    chk("sine_p_first", log_q[0][W-1], 1);
    chk("sine_p_last", log_q[127][W-2], 1);
    chk("busy_after_frame", busy, 0);

    // Sine, full-scale negative
    frame(WIN_SINE, {M2048, M2048});
    chk("sine_n_k0", ch(log_q[0], 0), -25);
    chk("sine_n_k127", ch(log_q[127], 1), -25);

    // Rect: ch0 = +2047, ch1 = -2048
    frame(WIN_RECT, {M2048, P2047});
    chk("rect_p_k0", ch(log_q[0], 0), 2047);
    chk("rect_n_k0", ch(log_q[0], 1), -2048);
    chk("rect_n_k64", ch(log_q[64], 1), -2048);

    // Hann
    frame(WIN_HANN, {P2047, P2047});
    chk("hann_k0", ch(log_q[0], 0), 0);
    v63 = ch(log_q[63], 0);
    chk("hann_k63_near", (v63 >= 2046 && v63 <= 2048), 1);
    sym = 1;
    for (int i = 0; i < N / 2; i++)
      for (int c = 0; c < NCH; c++)
        if (ch(log_q[i], c) !== ch(log_q[N-1-i], c)) sym = 0;
    chk("hann_symmetric", sym, 1);

    // Restart at sample 40
    log_q.delete();
    for (int i = 0; i < 40; i++) drive(i == 0, 1'b1, WIN_SINE, DWT'($urandom));
    chk("busy_mid_frame", busy, 1);
    chk("restart_err_before", restart_err, 0);
    drive(1'b1, 1'b1, WIN_RECT, DWT'($urandom));
    chk("restart_err_set", restart_err, 1);
    for (int i = 1; i < N; i++) drive(1'b0, 1'b1, WIN_SINE, DWT'($urandom));
    idle(6);
    drain();
    n_first = 0; n_last = 0;
    foreach (log_q[i]) begin
      if (log_q[i][W-1]) n_first++;
      if (log_q[i][W-2]) n_last++;
    end
    chk("restart_firsts", n_first, 2);
    chk("restart_lasts", n_last, 1);
    chk("restart_err_sticky", restart_err, 1);
    chk("busy_after_restart", busy, 0);

    // IDLE samples dropped, gapped frame with mode noise, reset mid-frame
    do_reset();
    chk("restart_err_cleared", restart_err, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, WIN_HANN, DWT'($urandom));
    for (int i = 0; i < 50; i++) begin
      drive(i == 0, 1'b1, (i == 0) ? WIN_SINE : 2'($urandom_range(0, 3)), DWT'($urandom));
      drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), '0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    n_at = obs_n;
    rst = 1'b0;
    m_run = 0; m_cnt = 0;
    idle(8);
    chk("no_out_after_rst", obs_n, n_at);
    drain();
    exp_q.delete(); lat_q.delete();

    // Bypass, random data with random gaps
    log_q.delete();
    for (int i = 0; i < N; i++) begin
      rd_data = DWT'($urandom);
      drive(i == 0, 1'b1, WIN_BYPASS, rd_data);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(6);
    drain();
    chk("bypass_count", log_q.size(), N);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
